// File: rtl/guess_pkg.sv
// Shared definitions for the guess tracker: FSM state encoding and the ASCII
// constants used for letter classification and display.
package guess_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
    } state_t;

    localparam logic [6:0] UNDERSCORE = 7'h5F;
    localparam logic [6:0] UPPER_A    = 7'h41;
    localparam logic [6:0] UPPER_Z    = 7'h5A;
    localparam logic [6:0] LOWER_A    = 7'h61;
    localparam logic [6:0] LOWER_Z    = 7'h7A;

endpackage

// File: rtl/guess_tracker_letter_index.sv
// Maps a 7-bit ASCII character to its case-folded alphabet index 0-25 and
// flags whether the character is a letter at all.
module letter_index
    import guess_pkg::*;
(
    input  logic [6:0] ascii,
    output logic [4:0] index,
    output logic       valid
);

    logic [6:0] offset_s;

    // Case-insensitive letter classification.
    always_comb begin
        offset_s = 7'd0;
        index    = 5'd0;
        valid    = 1'b0;
        if (ascii >= UPPER_A && ascii <= UPPER_Z) begin
            offset_s = ascii - UPPER_A;
            index    = offset_s[4:0];
            valid    = 1'b1;
        end else if (ascii >= LOWER_A && ascii <= LOWER_Z) begin
            offset_s = ascii - LOWER_A;
            index    = offset_s[4:0];
            valid    = 1'b1;
        end else begin
            offset_s = 7'd0;
            index    = 5'd0;
            valid    = 1'b0;
        end
    end

endmodule

// File: rtl/guess_tracker.sv
// Letter-guessing game tracker: holds a secret word, reveals slots as guesses
// match, counts misses and reports won/lost.
module guess_tracker
    import guess_pkg::*;
#(
    parameter int WORD_LEN   = 7,
    parameter int MAX_MISSES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_load,
    input  logic [7*WORD_LEN-1:0] word_in,
    input  logic                  guess_valid,
    input  logic [6:0]            guess_ascii,
    output logic                  guess_ready,
    output logic [7*WORD_LEN-1:0] disp,
    output logic                  hit,
    output logic                  miss,
    output logic                  dup,
    output logic                  bad,
    output logic [2:0]            miss_count,
    output logic                  won,
    output logic                  lost
);

    localparam logic [2:0] MAX_M = 3'(MAX_MISSES);

    state_t                state_r, state_n;
    logic [7*WORD_LEN-1:0] word_r, word_n;
    logic [WORD_LEN-1:0]   reveal_r, reveal_n;
    logic [25:0]           used_r, used_n;
    logic [2:0]            miss_cnt_r, miss_cnt_n;
    logic [6:0]            guess_r, guess_n;
    logic [7*WORD_LEN-1:0] disp_r, disp_n;
    logic                  hit_r, hit_n, miss_pulse_r, miss_pulse_n;
    logic                  dup_r, dup_n, bad_r, bad_n;
    logic                  won_r, lost_r, ready_r;

    logic [4:0]            guess_idx_s;
    logic                  guess_letter_s;
    logic [4:0]            slot_idx_s [WORD_LEN];
    logic [WORD_LEN-1:0]   slot_letter_s;
    logic [WORD_LEN-1:0]   match_s;

    letter_index u_guess_index (
        .ascii (guess_r),
        .index (guess_idx_s),
        .valid (guess_letter_s)
    );

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        letter_index u_slot_index (
            .ascii (word_r[7*i +: 7]),
            .index (slot_idx_s[i]),
            .valid (slot_letter_s[i])
        );
        assign match_s[i] = slot_letter_s[i] && (slot_idx_s[i] == guess_idx_s);
    end

    // Next-state, next-datapath and result-pulse logic.
    always_comb begin
        state_n      = state_r;
        word_n       = word_r;
        reveal_n     = reveal_r;
        used_n       = used_r;
        miss_cnt_n   = miss_cnt_r;
        guess_n      = guess_r;
        hit_n        = 1'b0;
        miss_pulse_n = 1'b0;
        dup_n        = 1'b0;
        bad_n        = 1'b0;
        disp_n       = {WORD_LEN{UNDERSCORE}};
        if (word_load) begin
            state_n    = LOAD;
            word_n     = word_in;
            reveal_n   = '0;
            used_n     = 26'd0;
            miss_cnt_n = 3'd0;
        end else begin
            case (state_r)
                IDLE: state_n = IDLE;
                LOAD: begin
                    // Spaces, digits and punctuation are never guessable.
                    reveal_n = ~slot_letter_s;
                    state_n  = (&reveal_n) ? WON : PLAY;
                end
                PLAY: begin
                    if (guess_valid) begin
                        guess_n = guess_ascii;
                        state_n = CHECK;
                    end else begin
                        state_n = PLAY;
                    end
                end
                CHECK: begin
                    if (!guess_letter_s) begin
                        bad_n = 1'b1;
                    end else if (used_r[guess_idx_s]) begin
                        dup_n = 1'b1;
                    end else begin
                        used_n[guess_idx_s] = 1'b1;
                        reveal_n = reveal_r | match_s;
                        if (|match_s) begin
                            hit_n = 1'b1;
                        end else begin
                            miss_pulse_n = 1'b1;
                            if (miss_cnt_r < MAX_M) begin
                                miss_cnt_n = miss_cnt_r + 3'd1;
                            end else begin
                                miss_cnt_n = miss_cnt_r;
                            end
                        end
                    end
                    if (&reveal_n) begin
                        state_n = WON;
                    end else if (miss_cnt_n == MAX_M) begin
                        state_n = LOST;
                    end else begin
                        state_n = PLAY;
                    end
                end
                WON:     state_n = WON;
                LOST:    state_n = LOST;
                default: state_n = IDLE;
            endcase
        end
        for (int i = 0; i < WORD_LEN; i++) begin
            if (reveal_n[i] || state_n == LOST) begin
                disp_n[7*i +: 7] = word_n[7*i +: 7];
            end else begin
                disp_n[7*i +: 7] = UNDERSCORE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_r       <= '0;
            reveal_r     <= '0;
            used_r       <= 26'd0;
            miss_cnt_r   <= 3'd0;
            guess_r      <= 7'd0;
            disp_r       <= {WORD_LEN{UNDERSCORE}};
            hit_r        <= 1'b0;
            miss_pulse_r <= 1'b0;
            dup_r        <= 1'b0;
            bad_r        <= 1'b0;
            won_r        <= 1'b0;
            lost_r       <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            word_r       <= word_n;
            reveal_r     <= reveal_n;
            used_r       <= used_n;
            miss_cnt_r   <= miss_cnt_n;
            guess_r      <= guess_n;
            disp_r       <= disp_n;
            hit_r        <= hit_n;
            miss_pulse_r <= miss_pulse_n;
            dup_r        <= dup_n;
            bad_r        <= bad_n;
            won_r        <= (state_n == WON);
            lost_r       <= (state_n == LOST);
            ready_r      <= (state_n == PLAY);
        end
    end

    assign guess_ready = ready_r;
    assign disp        = disp_r;
    assign hit         = hit_r;
    assign miss        = miss_pulse_r;
    assign dup         = dup_r;
    assign bad         = bad_r;
    assign miss_count  = miss_cnt_r;
    assign won         = won_r;
    assign lost        = lost_r;

endmodule

// File: doc/guess_tracker.md
GUESS_TRACKER -- requirements
Module: guess_tracker

Interface
REQ-001 The module SHALL have parameter WORD_LEN, default 7, number of character slots.
REQ-002 The module SHALL have parameter MAX_MISSES, default 6, number of misses that ends the game as lost.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The module SHALL have port word_load, input, 1, one-cycle strobe that loads word_in and starts a new game.
REQ-006 The module SHALL have port word_in, input, 7*WORD_LEN, secret word in 7-bit ASCII, with slot 1 at [6:0].
REQ-007 The module SHALL have port guess_valid, input, 1, a guess is offered.
REQ-008 The module SHALL have port guess_ascii, input, 7, the guessed character.
REQ-009 The module SHALL have port guess_ready, output, 1, high only in PLAY.
REQ-010 The module SHALL have port disp, output, 7*WORD_LEN, per slot: the word character if revealed, else 7'h5F ('_').
REQ-011 The module SHALL have ports hit, miss, dup and bad, each output, 1, one-cycle guess-result pulses.
REQ-012 The module SHALL have port miss_count, output, 3, misses in the current game.
REQ-013 The module SHALL have ports won and lost, each output, 1, levels that stay high while in the terminal state.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, PLAY, CHECK, WON and LOST.
REQ-015 In any state, word_load SHALL cause the next state to be LOAD, latch word_in, and clear the reveal mask, the used-letter mask and miss_count; word_load SHALL take priority over guess_valid.
REQ-016 LOAD SHALL last one cycle: slots holding non-letters are pre-revealed; the next state SHALL be WON if all slots are then revealed, else PLAY.
REQ-017 A guess SHALL be accepted on an edge where guess_valid && guess_ready: guess_ascii is latched and the next state is CHECK; throughput SHALL be one guess per 2 cycles.
REQ-018 Uppercase guesses (7'h41-7'h5A) SHALL be folded to lowercase; word characters SHALL be compared case-insensitively.
REQ-019 In CHECK, a non-letter guess SHALL pulse bad and change nothing else.
REQ-020 In CHECK, a letter already in the used mask SHALL pulse dup and change nothing else.
REQ-021 In CHECK, a new letter SHALL set its used bit, compare all WORD_LEN slots in parallel, and reveal every matching slot; one or more matches SHALL pulse hit, zero matches SHALL pulse miss and increment miss_count.
REQ-022 Result pulses and disp/miss_count updates SHALL be visible in the cycle after the CHECK edge, i.e. 2 edges after acceptance; exactly one of hit, miss, dup or bad SHALL pulse per guess.
REQ-023 After CHECK, the next state SHALL be WON if all slots are revealed, else LOST if miss_count == MAX_MISSES, else PLAY.
REQ-024 In LOST, disp SHALL show all slots revealed.
REQ-025 guess_valid in IDLE, LOAD, CHECK, WON or LOST SHALL be ignored, with no pulse.
REQ-026 miss_count SHALL never exceed MAX_MISSES.

Reset
REQ-027 rst SHALL take priority over word_load and SHALL put the FSM in IDLE.
REQ-028 On rst, disp SHALL be all 7'h5F.
REQ-029 On rst, the masks, miss_count, pulses, won, lost and guess_ready SHALL all be 0.
REQ-030 rst asserted during CHECK SHALL discard the pending guess with no pulse.

Structure
REQ-031 A shared package guess_pkg SHALL hold the state enum, the constant UNDERSCORE = 7'h5F, and the letter bounds 7'h41, 7'h5A, 7'h61 and 7'h7A.
REQ-032 One sub-module, letter_index, SHALL map ASCII to a 5-bit index 0-25 plus a valid flag, and SHALL be instantiated for the guess and for each word slot.

Verification
REQ-033 Load "hangman", guess 'a' -> hit; disp "_a___a_"; miss_count 0.
REQ-034 Guess 'N' after REQ-033 -> hit; disp "_an__an"; then guess 'n' -> dup; miss_count unchanged.
REQ-035 Guesses 'z','q','x','w','v','u' -> six miss pulses; miss_count 6; lost=1; disp "hangman"; a further guess_valid gives no pulse.
REQ-036 Guesses h,a,n,g,m -> won=1 in the cycle after the 'm' CHECK edge; guess_ready=0.
REQ-037 Guess '5' -> bad; no state change; then load "a b c d" -> spaces pre-revealed, disp "_ _ _ _".
REQ-038 word_load asserted together with guess_valid in PLAY -> the guess is dropped, all counters clear, and the new word is displayed all '_' for letter slots.
